// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: opcodes, 2-bit BHT counter states,
// condition evaluation and the saturating counter step.
package branch_pkg;

  localparam int unsigned OP_BZ   = 15;
  localparam int unsigned OP_BNZ  = 16;
  localparam int unsigned OP_BLTZ = 17;
  localparam int unsigned OP_BGTZ = 18;
  localparam int unsigned OP_BLEZ = 19;
  localparam int unsigned OP_BGEZ = 20;
  localparam int unsigned OP_B    = 21;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic logic is_branch(input int unsigned op);
    return (op >= OP_BZ) && (op <= OP_B);
  endfunction

  function automatic logic cond_taken(input int unsigned op, input logic zero, input logic neg);
    logic t;
    t = 1'b0;
    case (op)
      OP_BZ:   t = zero;
      OP_BNZ:  t = ~zero;
      OP_BLTZ: t = neg;
      OP_BGTZ: t = ~neg & ~zero;
      OP_BLEZ: t = neg | zero;
      OP_BGEZ: t = ~neg;
      OP_B:    t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t n;
    n = cur;
    case (cur)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = CTR_WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table of 2-bit saturating counters; one async lookup port and one RMW update port.
// Update lands on the clock edge, so a same-cycle lookup of the written entry sees the old counter.
module bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  ctr_t tbl [DEPTH];
  ctr_t upd_cur;
  ctr_t upd_nxt;

  assign rd_ctr  = tbl[rd_idx];
  assign upd_cur = tbl[upd_idx];
  assign upd_nxt = ctr_next(upd_cur, upd_taken);

  // Every entry restarts weakly not-taken so a fresh table predicts fall-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= CTR_WNT;
      end
    end else if (upd_en) begin
      tbl[upd_idx] <= upd_nxt;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches: condition, target, mispredict flush, BHT training, miss counter.
// Latency 1 cycle; never stalls, but a request in the cycle after a flush is dropped as wrong-path.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int ADDR_W    = 32,
  parameter int BHT_DEPTH = 16,
  parameter int MISS_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [OP_W-1:0]   res_op,
  input  logic              res_zero,
  input  logic              res_neg,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [ADDR_W-1:0] res_offset,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_taken,
  output logic              br_valid,
  output logic              br_taken,
  output logic              br_flush,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] br_redirect,
  output logic [MISS_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic              op_is_br;
  logic              op_is_uncond;
  logic              cond_t;
  logic              accept;
  logic              mispred;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  lk_idx;
  logic [1:0]        lk_ctr;
  logic              unused_lk_bits;

  always_comb begin
    op_is_br     = is_branch(32'(res_op));
    op_is_uncond = (32'(res_op) == OP_B);
    cond_t       = cond_taken(32'(res_op), res_zero, res_neg);
    // br_flush is the registered flush of the previous branch, so this request is wrong-path.
    accept       = res_valid & op_is_br & ~br_flush;
    mispred      = cond_t ^ res_pred_taken;
    seq_pc       = res_pc + ADDR_W'(4);
    tgt_pc       = seq_pc + (res_offset << 2);
    next_pc      = cond_t ? tgt_pc : seq_pc;
  end

  assign upd_idx        = res_pc[IDX_W+1:2];
  assign lk_idx         = lk_pc[IDX_W+1:2];
  assign lk_taken       = lk_ctr[1];
  assign unused_lk_bits = ^{lk_pc[ADDR_W-1:IDX_W+2], lk_pc[1:0], lk_ctr[0]};

  bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (lk_idx),
    .rd_ctr    (lk_ctr),
    .upd_en    (accept & ~op_is_uncond),
    .upd_idx   (upd_idx),
    .upd_taken (cond_t)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid <= 1'b0;
      br_flush <= 1'b0;
    end else begin
      br_valid <= accept;
      br_flush <= accept & mispred;
    end
  end

  // Result fields hold their last value between resolution pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken    <= 1'b0;
      br_target   <= '0;
      br_redirect <= '0;
    end else if (accept) begin
      br_taken    <= cond_t;
      br_target   <= tgt_pc;
      br_redirect <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (accept && mispred && (miss_cnt != {MISS_W{1'b1}})) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised + directed scoreboard bench for branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [5:0]  res_op = '0;
  logic        res_zero = 1'b0;
  logic        res_neg = 1'b0;
  logic [31:0] res_pc = '0;
  logic [31:0] res_offset = '0;
  logic        res_pred_taken = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        lk_taken;
  logic        br_valid, br_taken, br_flush;
  logic [31:0] br_target, br_redirect;
  logic [15:0] miss_cnt;

  logic        unused_lk2, unused_v2, unused_t2, unused_f2;
  logic [31:0] unused_tg2, unused_rd2;
  logic [1:0]  miss2;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_op(res_op),
    .res_zero(res_zero), .res_neg(res_neg), .res_pc(res_pc), .res_offset(res_offset),
    .res_pred_taken(res_pred_taken), .lk_pc(lk_pc), .lk_taken(lk_taken),
    .br_valid(br_valid), .br_taken(br_taken), .br_flush(br_flush),
    .br_target(br_target), .br_redirect(br_redirect), .miss_cnt(miss_cnt)
  );

  branch_resolve_unit #(.MISS_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_op(res_op),
    .res_zero(res_zero), .res_neg(res_neg), .res_pc(res_pc), .res_offset(res_offset),
    .res_pred_taken(res_pred_taken), .lk_pc(lk_pc), .lk_taken(unused_lk2),
    .br_valid(unused_v2), .br_taken(unused_t2), .br_flush(unused_f2),
    .br_target(unused_tg2), .br_redirect(unused_rd2), .miss_cnt(miss2)
  );

  typedef struct {
    bit          taken;
    bit          flush;
    logic [31:0] target;
    logic [31:0] redirect;
    int          miss;
    int          miss2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_bht [16];
  int   m_miss = 0;
  bit   m_flush_pending = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic bit m_taken(input int op, input bit z, input bit n);
    case (op)
      15: return z;
      16: return !z;
      17: return n;
      18: return !n && !z;
      19: return n || z;
      20: return !n;
      21: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 1;
    m_miss = 0;
    m_flush_pending = 0;
    q.delete();
  endtask

  // Monitor: pops an expectation whenever the DUT presents a resolution.
  always @(negedge clk) begin
    exp_t e;
    if (br_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("br_taken", br_taken, e.taken);
        chk("br_flush", br_flush, e.flush);
        chk("br_target", br_target, e.target);
        chk("br_redirect", br_redirect, e.redirect);
        chk("miss_cnt", miss_cnt, e.miss);
        chk("miss_cnt_w2", miss2, e.miss2);
      end
    end else begin
      chk("flush_without_valid", br_flush, 0);
    end
  end

  task automatic issue(input bit v, input int op, input bit z, input bit n,
                       input logic [31:0] pc, input logic [31:0] off,
                       input bit pred, input logic [31:0] lk);
    bit          acc, t, f;
    logic [31:0] tgt;
    exp_t        e;
    @(negedge clk);
    res_valid = v; res_op = 6'(op); res_zero = z; res_neg = n;
    res_pc = pc; res_offset = off; res_pred_taken = pred; lk_pc = lk;
    #1;
    chk("lk_taken", lk_taken, m_bht[m_idx(lk)] >= 2);
    acc = v && op >= 15 && op <= 21 && !m_flush_pending;
    t   = m_taken(op, z, n);
    f   = (t != pred);
    tgt = pc + 32'd4 + off * 32'd4;
    if (acc) begin
      if (op != 21) m_bht[m_idx(pc)] = t ? sat(m_bht[m_idx(pc)] + 1, 3)
                                          : ((m_bht[m_idx(pc)] > 0) ? m_bht[m_idx(pc)] - 1 : 0);
      if (f) m_miss++;
      e.taken = t; e.flush = f; e.target = tgt;
      e.redirect = t ? tgt : pc + 32'd4;
      e.miss = sat(m_miss, 65535); e.miss2 = sat(m_miss, 3);
      q.push_back(e);
    end
    m_flush_pending = acc && f;
  endtask

  task automatic idle(input logic [31:0] lk);
    issue(0, 0, 0, 0, 0, 0, 0, lk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    res_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_br_valid", br_valid, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_br_flush", br_flush, 0);
    chk("rst_br_target", br_target, 0);
    chk("rst_br_redirect", br_redirect, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_miss_cnt_w2", miss2, 0);
    lk_pc = 32'h0;        #1; chk("rst_lk_0", lk_taken, 0);
    lk_pc = 32'h40;       #1; chk("rst_lk_40", lk_taken, 0);
    lk_pc = 32'hFFFFFFFC; #1; chk("rst_lk_fffc", lk_taken, 0);
    @(negedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] pcs [5];
    int          op;
    logic [31:0] off, pc;
    pcs[0] = 32'h0; pcs[1] = 32'h40; pcs[2] = 32'h100; pcs[3] = 32'hFFFFFFFC; pcs[4] = 32'h4;

    do_reset();

    // Taken BZ mispredicted, then not-taken BNZ, then a backward target wrapping below zero.
    issue(1, 15, 1, 0, 32'h100, 32'd3, 0, 32'h100);
    idle(32'h100);
    issue(1, 16, 1, 0, 32'h100, 32'd0, 0, 32'h100);
    issue(1, 18, 0, 0, 32'h4, -32'sd3, 0, 32'h4);
    idle(32'h0);

    // BHT training at 0x40.
    issue(1, 15, 1, 0, 32'h40, 32'd1, 1, 32'h40);
    idle(32'h40);
    repeat (3) issue(1, 15, 1, 0, 32'h40, 32'd1, 1, 32'h40);
    issue(1, 15, 0, 0, 32'h40, 32'd1, 0, 32'h40);
    idle(32'h40);
    repeat (2) issue(1, 15, 0, 0, 32'h40, 32'd1, 0, 32'h40);
    idle(32'h40);
    issue(1, 21, 0, 0, 32'h40, 32'd2, 1, 32'h40);
    idle(32'h40);

    // Squash: request right after a flush is dropped; the next one is accepted.
    issue(1, 15, 1, 0, 32'h80, 32'd5, 0, 32'h40);
    issue(1, 15, 1, 0, 32'h40, 32'd5, 0, 32'h40);
    issue(1, 16, 0, 0, 32'h40, 32'd7, 1, 32'h40);
    idle(32'h40);

    // Non-branch opcode.
    issue(1, 8, 1, 0, 32'h40, 32'd1, 0, 32'h40);
    idle(32'h40);

    // Five mispredicts saturate the 2-bit counter.
    repeat (5) begin
      issue(1, 17, 0, 1, 32'h200, 32'd8, 0, 32'h200);
      idle(32'h200);
    end

    // Reset while a flush is pending.
    issue(1, 15, 1, 0, 32'h40, 32'd1, 0, 32'h40);
    do_reset();
    issue(1, 15, 1, 0, 32'h40, 32'd1, 1, 32'h40);
    idle(32'h40);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0: op = 8;
        1: op = $urandom_range(0, 63);
        default: op = $urandom_range(15, 21);
      endcase
      off = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
      pc  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFFFFFC) : pcs[$urandom_range(0, 4)];
      issue($urandom_range(0, 9) < 8, op, 1'($urandom()), 1'($urandom()), pc, off,
            1'($urandom()), pcs[$urandom_range(0, 4)]);
    end

    repeat (3) idle(32'h0);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered branch-resolution unit for the pipelined datapath: evaluates the branch condition for opcodes 15–21 from ALU flags, computes the target, detects mispredictions against the fetch-stage guess, and trains a parametrised 2-bit branch history table (BHT) that the fetch stage reads for its prediction. It sits between the EX stage (flags, PC, offset) and the PC-select/flush logic. It extends the earlier single-flag combinational branch decision with multiple condition modes, prediction and flush generation.

## Interface
- OP_W, 6, opcode width
- ADDR_W, 32, PC/target width
- BHT_DEPTH, 16, BHT entries (power of two, ≥2); IDX_W = log2(BHT_DEPTH)
- MISS_W, 16, mispredict counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- res_valid  in  1  resolution request this cycle
- res_op  in  OP_W  opcode
- res_zero, res_neg  in  1 each  ALU zero / negative flags
- res_pc  in  ADDR_W  PC of the branch
- res_offset  in  ADDR_W  sign-extended word offset
- res_pred_taken  in  1  prediction used at fetch
- lk_pc  in  ADDR_W  fetch-stage lookup PC
- lk_taken  out  1  combinational prediction = BHT[lk_pc[IDX_W+1:2]][1]
- br_valid  out  1  registered resolution pulse
- br_taken, br_flush  out  1 each  outcome / mispredict
- br_target, br_redirect  out  ADDR_W  branch target / correct next PC
- miss_cnt  out  MISS_W  saturating mispredict count

## Operation
- Conditions: 15 BZ (zero), 16 BNZ (!zero), 17 BLTZ (neg), 18 BGTZ (!neg & !zero), 19 BLEZ (neg | zero), 20 BGEZ (!neg), 21 B (always taken). Any other opcode: not a branch.
- Target = res_pc + 4 + (res_offset << 2), truncated mod 2^ADDR_W (wraps both ways).
- Redirect = taken ? target : res_pc + 4. Flush = taken != res_pred_taken.
- Accepted request: res_valid & branch opcode & not squashed. Non-branch or squashed: br_valid=0, no BHT/counter change.
- Squash: a request arriving in the cycle where registered br_flush=1 is wrong-path and is dropped.
- BHT: index = res_pc[IDX_W+1:2]; counters 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Accepted opcodes 15–20: taken → saturating increment, not taken → saturating decrement. Opcode 21 does not update the BHT.
- miss_cnt increments on each accepted flush; saturates at all-ones.

## Timing
- Latency 1: accepted request at edge N → br_valid, br_taken, br_flush, br_target, br_redirect valid after edge N.
- br_valid and br_flush are single-cycle pulses; br_taken, br_target and br_redirect hold their last value while br_valid=0.
- BHT write on the accept edge. Same-cycle lookup of the index being written returns the old value; the new value is visible the next cycle.
- Back-to-back accepted requests are allowed every cycle when no flush is pending.
- Reset (any time, including mid-stream): all outputs 0, miss_cnt 0, every BHT entry 01 (lk_taken=0). A pending squash is cleared.

## Structure
- Package branch_pkg: opcode constants (OP_BZ=15 … OP_B=21), 2-bit counter state enum, condition-evaluation function.
- Sub-module bht: BHT_DEPTH×2-bit table with async-reset init, one read port (lookup) and one read-modify-write update port. Top handles decode, target arithmetic, output registers, squash and miss_cnt.

## Test plan
- Reset: deassert rst_n mid-stream → all outputs 0, lk_taken=0 for lk_pc 0x0/0x40/0xFFFFFFFC, miss_cnt=0.
- op=15, zero=1, pc=0x100, offset=3, pred=0 → next cycle br_valid=1, taken=1, target=0x110, flush=1, redirect=0x110, miss_cnt=1.
- op=16, zero=1, pc=0x100, pred=0 → taken=0, flush=0, redirect=0x104. Then op=18, neg=0, zero=0, pc=0x4, offset=-3 → target=0xFFFFFFFC.
- BHT training at pc=0x40: one taken op=15 → lk_taken(0x40)=1. Three taken then one not-taken → still 1. Two more not-taken → 0. op=21 at 0x40 leaves the entry unchanged.
- Squash: flush pulse, then res_valid op=15 in the next cycle → br_valid=0, BHT and miss_cnt unchanged. The following request is accepted normally.
- op=8 with res_valid → br_valid=0, no BHT change. Drive MISS_W=2 with 5 mispredicts → miss_cnt holds at 3.
